// File: rtl/udp_ctrl_pkg.sv
// Shared types and constants for the UDP loopback RAM port controller.
// Holds the default payload table and the default TX lengths.
package udp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_PRELOAD     = 2'd0,
    ST_RUN         = 2'd1,
    ST_RELOAD_PEND = 2'd2
  } state_t;

  localparam int          MSG_WORDS         = 5;
  localparam logic [15:0] UDP_DEF_DATA_LEN  = 16'd28;
  localparam logic [15:0] IP_DEF_TOTAL_LEN  = 16'd48;

  // "HELLO ALINX AX7101\n\r", first byte in the top lane
  function automatic logic [31:0] msg_word(input logic [2:0] idx);
    logic [31:0] w;
    case (idx)
      3'd0:    w = 32'h48454C4C;
      3'd1:    w = 32'h4F20414C;
      3'd2:    w = 32'h494E5820;
      3'd3:    w = 32'h41583731;
      3'd4:    w = 32'h30310A0D;
      default: w = 32'h00000000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/udp_ram_port_ctrl.sv
// Owns write port A of the UDP loopback RAM: preloads the default payload,
// then mirrors the UDP receiver, and selects the TX length pair.
//
// state          | meaning
// ST_PRELOAD     | writing the default payload, receiver writes dropped
// ST_RUN         | port mirrors the receiver
// ST_RELOAD_PEND | reload requested, waiting for the receiver to go idle
module udp_ram_port_ctrl
  import udp_ctrl_pkg::*;
#(
  parameter int          ADDR_W        = 9,
  parameter int          BASE_ADDR     = 1,
  parameter logic [15:0] DEF_DATA_LEN  = UDP_DEF_DATA_LEN,
  parameter logic [15:0] DEF_TOTAL_LEN = IP_DEF_TOTAL_LEN
) (
  input  logic              e_rxc,
  input  logic              reset_n,
  input  logic              reload,
  input  logic              rx_busy,
  input  logic              rx_wr_en,
  input  logic [ADDR_W-1:0] rx_wr_addr,
  input  logic [31:0]       rx_wr_data,
  input  logic              rx_data_receive,
  input  logic [15:0]       rx_data_length,
  input  logic [15:0]       rx_total_length,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [31:0]       ram_dina,
  output logic              preload_done,
  output logic [15:0]       tx_data_length,
  output logic [15:0]       tx_total_length,
  output logic [15:0]       rx_drop_cnt
);

  localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
  localparam logic [2:0]        LAST_IDX = 3'(MSG_WORDS - 1);

  state_t              state, state_nxt;
  logic [2:0]          idx, idx_nxt;
  logic                rx_seen, rx_seen_nxt;
  logic                wea_nxt;
  logic [ADDR_W-1:0]   addra_nxt;
  logic [31:0]         dina_nxt;
  logic                done_nxt;
  logic [15:0]         drop_nxt;
  logic                rx_idle;

  assign rx_idle = !rx_busy && !rx_wr_en;

  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_PRELOAD;
      idx          <= 3'd0;
      rx_seen      <= 1'b0;
      ram_wea      <= 1'b0;
      ram_addra    <= '0;
      ram_dina     <= 32'h0;
      preload_done <= 1'b0;
      rx_drop_cnt  <= 16'h0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      rx_seen      <= rx_seen_nxt;
      ram_wea      <= wea_nxt;
      ram_addra    <= addra_nxt;
      ram_dina     <= dina_nxt;
      preload_done <= done_nxt;
      rx_drop_cnt  <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    rx_seen_nxt = rx_seen;
    wea_nxt     = 1'b0;
    addra_nxt   = ram_addra;
    dina_nxt    = ram_dina;
    done_nxt    = preload_done;
    drop_nxt    = rx_drop_cnt;
    case (state)
      ST_PRELOAD: begin
        wea_nxt   = 1'b1;
        addra_nxt = BASE + ADDR_W'(idx);
        dina_nxt  = msg_word(idx);
        if (rx_wr_en && rx_drop_cnt != 16'hFFFF)
          drop_nxt = rx_drop_cnt + 16'd1;
        if (idx == LAST_IDX) begin
          state_nxt = ST_RUN;
          done_nxt  = 1'b1;
          idx_nxt   = 3'd0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      ST_RUN, ST_RELOAD_PEND: begin
        wea_nxt   = rx_wr_en;
        addra_nxt = rx_wr_addr;
        dina_nxt  = rx_wr_data;
        if (rx_data_receive)
          rx_seen_nxt = 1'b1;
        // a pending reload only fires once the receiver is between frames
        if (reload || state == ST_RELOAD_PEND) begin
          if (rx_idle) begin
            state_nxt   = ST_PRELOAD;
            done_nxt    = 1'b0;
            rx_seen_nxt = 1'b0;
          end else begin
            state_nxt = ST_RELOAD_PEND;
          end
        end
      end
      default: state_nxt = ST_PRELOAD;
    endcase
  end

  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_length  <= DEF_DATA_LEN;
      tx_total_length <= DEF_TOTAL_LEN;
    end else begin
      tx_data_length  <= rx_seen ? rx_data_length  : DEF_DATA_LEN;
      tx_total_length <= rx_seen ? rx_total_length : DEF_TOTAL_LEN;
    end
  end

endmodule

// File: tb/tb_udp_ram_port_ctrl.sv
// Bench for udp_ram_port_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the port owner.
module tb_udp_ram_port_ctrl;

  logic        e_rxc = 1'b0;
  logic        reset_n;
  logic        reload, rx_busy, rx_wr_en, rx_data_receive;
  logic [8:0]  rx_wr_addr;
  logic [31:0] rx_wr_data;
  logic [15:0] rx_data_length, rx_total_length;
  logic        ram_wea, preload_done;
  logic [8:0]  ram_addra;
  logic [31:0] ram_dina;
  logic [15:0] tx_data_length, tx_total_length, rx_drop_cnt;

  always #5 e_rxc = ~e_rxc;

  udp_ram_port_ctrl dut (
    .e_rxc           (e_rxc),
    .reset_n         (reset_n),
    .reload          (reload),
    .rx_busy         (rx_busy),
    .rx_wr_en        (rx_wr_en),
    .rx_wr_addr      (rx_wr_addr),
    .rx_wr_data      (rx_wr_data),
    .rx_data_receive (rx_data_receive),
    .rx_data_length  (rx_data_length),
    .rx_total_length (rx_total_length),
    .ram_wea         (ram_wea),
    .ram_addra       (ram_addra),
    .ram_dina        (ram_dina),
    .preload_done    (preload_done),
    .tx_data_length  (tx_data_length),
    .tx_total_length (tx_total_length),
    .rx_drop_cnt     (rx_drop_cnt)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // model: words of payload still to write, pending-reload flag, frame-seen flag
  int          m_left;
  logic        m_pend, m_seen;
  logic        exp_wea, exp_done;
  logic [8:0]  exp_addr;
  logic [31:0] exp_din;
  logic [15:0] exp_tdl, exp_ttl, exp_drop;

  function automatic logic [31:0] msg_of(input int k);
    string s;
    s = "HELLO ALINX AX7101\n\r";
    return {s[4*k], s[4*k+1], s[4*k+2], s[4*k+3]};
  endfunction

  task automatic model_reset;
    m_left   = 5;
    m_pend   = 1'b0;
    m_seen   = 1'b0;
    exp_wea  = 1'b0;
    exp_addr = 9'd0;
    exp_din  = 32'd0;
    exp_done = 1'b0;
    exp_drop = 16'd0;
    exp_tdl  = 16'd28;
    exp_ttl  = 16'd48;
  endtask

  task automatic model_step;
    int k;
    exp_tdl = m_seen ? rx_data_length  : 16'd28;
    exp_ttl = m_seen ? rx_total_length : 16'd48;
    if (m_left > 0) begin
      k        = 5 - m_left;
      exp_wea  = 1'b1;
      exp_addr = 9'((1 + k) % 512);
      exp_din  = msg_of(k);
      m_left--;
      if (m_left == 0) exp_done = 1'b1;
      if (rx_wr_en && exp_drop != 16'hFFFF) exp_drop++;
    end else begin
      exp_wea  = rx_wr_en;
      exp_addr = rx_wr_addr;
      exp_din  = rx_wr_data;
      if (rx_data_receive) m_seen = 1'b1;
      if (reload) m_pend = 1'b1;
      if (m_pend && !rx_busy && !rx_wr_en) begin
        m_pend   = 1'b0;
        m_left   = 5;
        m_seen   = 1'b0;
        exp_done = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".wea"},  32'(ram_wea),         32'(exp_wea));
    chk({tag, ".addr"}, 32'(ram_addra),       32'(exp_addr));
    chk({tag, ".din"},  ram_dina,             exp_din);
    chk({tag, ".done"}, 32'(preload_done),    32'(exp_done));
    chk({tag, ".tdl"},  32'(tx_data_length),  32'(exp_tdl));
    chk({tag, ".ttl"},  32'(tx_total_length), 32'(exp_ttl));
    chk({tag, ".drop"}, 32'(rx_drop_cnt),     32'(exp_drop));
  endtask

  task automatic cycle(input logic rl, input logic bz, input logic we,
                       input logic [8:0] a, input logic [31:0] d, input logic rcv,
                       input logic [15:0] dl, input logic [15:0] tl, input string tag);
    reload          = rl;
    rx_busy         = bz;
    rx_wr_en        = we;
    rx_wr_addr      = a;
    rx_wr_data      = d;
    rx_data_receive = rcv;
    rx_data_length  = dl;
    rx_total_length = tl;
    model_step();
    @(posedge e_rxc);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 16'd40, 16'd60, tag);
  endtask

  initial begin
    logic bz;
    reset_n = 1'b0;
    reload = 0; rx_busy = 0; rx_wr_en = 0; rx_wr_addr = 0; rx_wr_data = 0;
    rx_data_receive = 0; rx_data_length = 0; rx_total_length = 0;
    model_reset();
    #12;
    check_outputs("rst");
    reset_n = 1'b1;

    // preload window with three receiver writes that must be dropped
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b0, (i % 2 == 0), 9'h1FF, 32'hBAD0_0000 + i, 1'b0, 16'd0, 16'd0, "pre");
    chk("drop3", 32'(rx_drop_cnt), 32'd3);
    chk("done", 32'(preload_done), 32'd1);
    idle(3, "idle");
    chk("def_len", 32'(tx_data_length), 32'd28);

    cycle(1'b0, 1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 1'b0, 16'd0, 16'd0, "wr");
    chk("wr_data", ram_dina, 32'hDEADBEEF);

    cycle(1'b0, 1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 16'd40, 16'd60, "rcv");
    idle(2, "rcv_wait");
    chk("rx_len", 32'(tx_total_length), 32'd60);

    cycle(1'b1, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 16'd40, 16'd60, "reload");
    idle(8, "reload_pre");
    chk("len_back", 32'(tx_data_length), 32'd28);

    // reload while receiver busy, second reload absorbed
    cycle(1'b0, 1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 16'd40, 16'd60, "rcv2");
    cycle(1'b1, 1'b1, 1'b1, 9'h020, 32'h1111_0000, 1'b0, 16'd40, 16'd60, "pend");
    for (int i = 0; i < 10; i++)
      cycle((i == 4), 1'b1, (i % 3 != 2), 9'($urandom), $urandom, 1'b0, 16'd40, 16'd60, "pend_busy");
    idle(12, "pend_pre");

    // random traffic
    bz = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bz = ~bz;
      cycle(($urandom_range(0, 29) == 0), bz,
            bz ? 1'($urandom) : ($urandom_range(0, 9) == 0),
            9'($urandom), $urandom, ($urandom_range(0, 9) == 0),
            16'($urandom), 16'($urandom), "rand");
    end

    // reset in the middle of a preload
    idle(6, "pre_rst");
    cycle(1'b1, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 16'd40, 16'd60, "reload2");
    idle(2, "pre_rst_w");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_mid");
    #4 reset_n = 1'b1;
    idle(7, "restart");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
